// File: rtl/mdu_pkg.sv
// Shared CPU constants for the multiply/divide unit: MDOp encodings and
// default busy-cycle counts, also used by ctrl_E and the stall unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at acceptance and held pending until the commit edge.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            busy_n;
    logic [31:0]     hi_n, lo_n;
    logic [31:0]     pend_hi, pend_lo;
    logic            pend_we;
    logic            load;
    logic [31:0]     res_hi, res_lo;
    logic            res_we;
    logic [63:0]     ext_a, ext_b, prod;

    // Operand arithmetic; only sampled into the pending registers on acceptance.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_we = 1'b1;
        ext_a  = '0;
        ext_b  = '0;
        prod   = '0;
        case (MDOp)
            MD_MULT, MD_MULTU: begin
                ext_a = (MDOp == MD_MULT) ? {{32{A[31]}}, A} : {32'd0, A};
                ext_b = (MDOp == MD_MULT) ? {{32{B[31]}}, B} : {32'd0, B};
                prod  = ext_a * ext_b;
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            MD_DIV: begin
                if (B == '0) begin
                    res_we = 1'b0;
                end else if (A == 32'h8000_0000 && B == '1) begin
                    // Quotient overflow wraps to the dividend with zero remainder.
                    res_lo = A;
                    res_hi = '0;
                end else begin
                    res_lo = $signed(A) / $signed(B);
                    res_hi = $signed(A) % $signed(B);
                end
            end
            MD_DIVU: begin
                if (B == '0) begin
                    res_we = 1'b0;
                end else begin
                    res_lo = A / B;
                    res_hi = A % B;
                end
            end
            default: res_we = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy_n  = Busy;
        hi_n    = HI;
        lo_n    = LO;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    case (MDOp)
                        MD_MULT, MD_MULTU: begin
                            state_n = RUN;
                            busy_n  = 1'b1;
                            cnt_n   = CW'(MULT_CYCLES);
                            load    = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_n = RUN;
                            busy_n  = 1'b1;
                            cnt_n   = CW'(DIV_CYCLES);
                            load    = 1'b1;
                        end
                        MD_MTHI: hi_n = A;
                        MD_MTLO: lo_n = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                    if (pend_we) begin
                        hi_n = pend_hi;
                        lo_n = pend_lo;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            Busy    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            Busy  <= busy_n;
            HI    <= hi_n;
            LO    <= lo_n;
            if (load) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_we <= res_we;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: expected HI/LO results are queued when an
// operation is issued and compared when Busy falls.
module tb_mdu;
    import mdu_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  MDOp = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic [31:0] HI, LO;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [63:0] exp_q[$];

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                          input logic [31:0] ohi, olo);
        longint sq, sr;
        logic [63:0] r;
        r = {ohi, olo};
        case (op)
            MD_MULT:  r = 64'(longint'($signed(a)) * longint'($signed(b)));
            MD_MULTU: r = {32'd0, a} * {32'd0, b};
            MD_DIV: if (b != 0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                r = {sr[31:0], sq[31:0]};
            end
            MD_DIVU: if (b != 0) r = {a % b, a / b};
            default: ;
        endcase
        return r;
    endfunction

    // Issue one operation, check Busy length and HI/LO hold, then pop the expected result.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, b,
                          input logic [63:0] expv, input int unsigned n);
        logic [31:0] old_hi, old_lo;
        logic [63:0] e;
        int unsigned cnt;
        old_hi = HI;
        old_lo = LO;
        Start = 1'b1; MDOp = op; A = a; B = b;
        exp_q.push_back(expv);
        tick();
        Start = 1'b0;
        cnt = 0;
        while (Busy && cnt < 100) begin
            checks++;
            if (HI !== old_hi || LO !== old_lo) begin
                errors++;
                $display("FAIL %s_hold: HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, old_hi, old_lo);
            end
            cnt++;
            tick();
        end
        checks++;
        if (cnt != n) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d cycles expected %0d", name, cnt, n);
        end
        e = exp_q.pop_front();
        checks++;
        if ({HI, LO} !== e) begin
            errors++;
            $display("FAIL %s_result: HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_reset();
        Start = 1'b1; MDOp = MD_MULT; A = 32'd7; B = 32'd9;
        repeat (2) tick();
        checks++;
        if (Busy !== 1'b0 || HI !== '0 || LO !== '0) begin
            errors++;
            $display("FAIL reset_state: Busy=%b HI=%h LO=%h expected 0/0/0", Busy, HI, LO);
        end
        Start = 1'b0;
        // Release mid-cycle with an MTHI pending: must land on the first edge.
        Start = 1'b1; MDOp = MD_MTHI; A = 32'h0000_0055;
        Reset = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if (HI !== 32'h0000_0055 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_start: HI=%h Busy=%b expected HI=00000055 Busy=0", HI, Busy);
        end
    endtask

    task automatic test_mult();
        run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5);
    endtask

    task automatic test_div();
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 10);
        run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, {HI, LO}, 10);
        run_op("div_zero", MD_DIV, 32'h8000_0000, 32'd0, {HI, LO}, 10);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10);
    endtask

    task automatic test_mthi_mtlo();
        logic seen_busy;
        seen_busy = 1'b0;
        Start = 1'b1; MDOp = MD_MTHI; A = 32'h1234_5678;
        tick();
        seen_busy |= Busy;
        checks++;
        if (HI !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mthi: HI=%h expected 12345678", HI);
        end
        MDOp = MD_MTLO; A = 32'hCAFE_BABE;
        tick();
        seen_busy |= Busy;
        checks++;
        if (LO !== 32'hCAFE_BABE || HI !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mtlo: HI=%h LO=%h expected HI=12345678 LO=cafebabe", HI, LO);
        end
        MDOp = 3'd6; A = 32'hDEAD_BEEF;
        tick();
        MDOp = 3'd7;
        tick();
        seen_busy |= Busy;
        Start = 1'b0;
        checks++;
        if (HI !== 32'h1234_5678 || LO !== 32'hCAFE_BABE || seen_busy !== 1'b0) begin
            errors++;
            $display("FAIL mt_noop: HI=%h LO=%h busy_seen=%b expected 12345678/cafebabe/0", HI, LO, seen_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic bad;
        Start = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        #1;
        checks++;
        if (HI !== '0 || LO !== '0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: HI=%h LO=%h Busy=%b expected 0/0/0", HI, LO, Busy);
        end
        tick();
        Reset = 1'b1;
        bad = 1'b0;
        repeat (15) begin
            tick();
            if (HI !== '0 || LO !== '0 || Busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_no_commit: HI=%h LO=%h Busy=%b expected 0/0/0", HI, LO, Busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        int unsigned cnt;
        Start = 1'b1; MDOp = MD_MULT; A = 32'hFFFF_FFFD; B = 32'd4;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF4);
        tick();
        MDOp = MD_MULTU; A = 32'h0001_0000; B = 32'h0001_0003;
        exp_q.push_back(64'h0000_0001_0003_0000);
        cnt = 0;
        while (Busy && cnt < 100) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 5) begin
            errors++;
            $display("FAIL b2b_first_len: got %0d cycles expected 5", cnt);
        end
        e = exp_q.pop_front();
        checks++;
        if ({HI, LO} !== e || Busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_result: HI=%h LO=%h Busy=%b expected HI=%h LO=%h Busy=0",
                     HI, LO, Busy, e[63:32], e[31:0]);
        end
        tick();
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: Busy=%b expected 1", Busy);
        end
        cnt = 0;
        while (Busy && cnt < 100) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 5) begin
            errors++;
            $display("FAIL b2b_second_len: got %0d cycles expected 5", cnt);
        end
        e = exp_q.pop_front();
        checks++;
        if ({HI, LO} !== e) begin
            errors++;
            $display("FAIL b2b_second_result: HI=%h LO=%h expected HI=%h LO=%h", HI, LO, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
            if (i == 1) b = 32'hFFFF_FFF0;
            run_op("random", op, a, b, model(op, a, b, HI, LO), (op < 3'd2) ? 5 : 10);
        end
    endtask

    initial begin
        #1;
        test_reset();
        tick();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
